vga_sync_rx: RTL

Receive-side counterpart of the VGA timing generators. Takes hsync/vsync/DE from a timing source synchronous to the pixel clock (our own generator, or an external video source) and recovers column/row position, measured line timing and a lock indication. Sits between the video input pins and downstream pixel consumers (frame capture, overlay, timing checker).

---
 rtl/vga_timing_pkg.sv | 21 ++
 rtl/sync_edge_det.sv | 34 +++
 rtl/vga_sync_rx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions used by the generators and the sync receiver.
package vga_timing_pkg;

  // Receiver lock state
  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_LOCKED = 2'd2
  } sync_state_t;

  // Default width of pixel/line counters
  localparam int unsigned CNT_W_DEF = 12;

  // Standard line timing, in pixel clocks
  localparam int unsigned H_ACTIVE = 480;
  localparam int unsigned H_FRONT  = 8;
  localparam int unsigned H_SYNC   = 41;
  localparam int unsigned H_BACK   = 4;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

endpackage

// File: rtl/sync_edge_det.sv
// Registers an input once, keeps a second stage for edge detection and
// reports the asserted level plus assert/deassert pulses.
module sync_edge_det
  import vga_timing_pkg::*;
#(
  parameter bit POL = 1'b1
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_sig,
  output logic o_lvl,
  output logic o_assert,
  output logic o_deassert
);

  logic r_s1;
  logic r_s2;

  // Two-stage capture; reset to the deasserted level so no edge fires on release
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_s1 <= ~POL;
      r_s2 <= ~POL;
    end else begin
      r_s1 <= i_sig;
      r_s2 <= r_s1;
    end
  end

  assign o_lvl      = (r_s1 == POL);
  assign o_assert   = (r_s1 == POL) && (r_s2 != POL);
  assign o_deassert = (r_s1 != POL) && (r_s2 == POL);

endmodule

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: recovers pixel/line position, measures line timing
// and tracks lock on consecutive equal-length lines.
module vga_sync_rx
  import vga_timing_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned LOCK_LINES = 4,
  parameter bit          SYNC_POL   = 1'b0
) (
  input  logic             pxclk_i,
  input  logic             resetn_i,
  input  logic             hsync_i,
  input  logic             vsync_i,
  input  logic             de_i,
  output logic             locked_o,
  output logic [CNT_W-1:0] line_len_o,
  output logic [CNT_W-1:0] hsync_len_o,
  output logic [CNT_W-1:0] active_len_o,
  output logic [CNT_W-1:0] col_o,
  output logic [CNT_W-1:0] row_o,
  output logic             active_o,
  output logic             frame_o
);

  localparam int unsigned MW = $clog2(LOCK_LINES + 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [MW-1:0]    M_ONE  = MW'(1);
  localparam logic [MW-1:0]    M_LOCK = MW'(LOCK_LINES);

  logic w_hs_lvl, w_hs_start, w_hs_end;
  logic w_vs_lvl, w_vs_start, w_vs_end;
  logic w_de, w_de_start, w_de_end;
  logic w_unused;

  sync_edge_det #(.POL(SYNC_POL)) u_hs (
    .i_clk(pxclk_i), .i_resetn(resetn_i), .i_sig(hsync_i),
    .o_lvl(w_hs_lvl), .o_assert(w_hs_start), .o_deassert(w_hs_end)
  );

  sync_edge_det #(.POL(SYNC_POL)) u_vs (
    .i_clk(pxclk_i), .i_resetn(resetn_i), .i_sig(vsync_i),
    .o_lvl(w_vs_lvl), .o_assert(w_vs_start), .o_deassert(w_vs_end)
  );

  sync_edge_det #(.POL(1'b1)) u_de (
    .i_clk(pxclk_i), .i_resetn(resetn_i), .i_sig(de_i),
    .o_lvl(w_de), .o_assert(w_de_start), .o_deassert(w_de_end)
  );

  assign w_unused = &{1'b0, w_vs_lvl, w_vs_end, w_de_start, w_de_end};

  sync_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_ref, w_ref_nxt;
  logic             r_ref_vld, w_ref_vld_nxt;
  logic [MW-1:0]    r_match, w_match_nxt;
  logic [CNT_W-1:0] r_pcnt;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_acnt;
  logic [CNT_W-1:0] r_line_len, r_hsync_len, r_active_len;
  logic [CNT_W-1:0] r_col, r_row;
  logic             r_active, r_frame;
  logic [CNT_W-1:0] w_len;
  logic             w_ovf;

  assign w_len = r_pcnt + ONE;
  // A sync edge on the saturating cycle still counts as a valid line end
  assign w_ovf = (r_pcnt == '1) && !w_hs_start;

  // Lock state, reference length and match count register
  always_ff @(posedge pxclk_i) begin
    if (!resetn_i) begin
      r_state   <= ST_SEARCH;
      r_ref     <= '0;
      r_ref_vld <= 1'b0;
      r_match   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ref     <= w_ref_nxt;
      r_ref_vld <= w_ref_vld_nxt;
      r_match   <= w_match_nxt;
    end
  end

  // Next lock state from measured line length at each hsync start
  always_comb begin
    w_state_nxt   = r_state;
    w_ref_nxt     = r_ref;
    w_ref_vld_nxt = r_ref_vld;
    w_match_nxt   = r_match;
    if (w_hs_start) begin
      case (r_state)
        ST_SEARCH: begin
          w_state_nxt   = ST_TRAIN;
          w_match_nxt   = '0;
          w_ref_vld_nxt = 1'b0;
        end
        ST_TRAIN: begin
          if (r_ref_vld && (w_len == r_ref)) begin
            w_match_nxt = r_match + M_ONE;
          end else begin
            w_ref_nxt     = w_len;
            w_ref_vld_nxt = 1'b1;
            w_match_nxt   = M_ONE;
          end
          if (w_match_nxt == M_LOCK) begin
            w_state_nxt = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_len != r_ref) begin
            w_state_nxt   = ST_TRAIN;
            w_ref_nxt     = w_len;
            w_ref_vld_nxt = 1'b1;
            w_match_nxt   = M_ONE;
          end
        end
        default: w_state_nxt = ST_SEARCH;
      endcase
    end else if (w_ovf) begin
      w_state_nxt   = ST_SEARCH;
      w_ref_nxt     = '0;
      w_ref_vld_nxt = 1'b0;
      w_match_nxt   = '0;
    end
  end

  // Pixel counter since last hsync start, saturating at all-ones
  always_ff @(posedge pxclk_i) begin
    if (!resetn_i) begin
      r_pcnt <= '0;
    end else if (w_hs_start) begin
      r_pcnt <= '0;
    end else if (r_pcnt != '1) begin
      r_pcnt <= r_pcnt + ONE;
    end
  end

  // Line, sync-width and active-width measurements
  always_ff @(posedge pxclk_i) begin
    if (!resetn_i) begin
      r_hcnt       <= '0;
      r_acnt       <= '0;
      r_line_len   <= '0;
      r_hsync_len  <= '0;
      r_active_len <= '0;
    end else begin
      if (w_hs_start) begin
        r_hcnt <= ONE;
      end else if (w_hs_lvl) begin
        r_hcnt <= r_hcnt + ONE;
      end
      if (w_hs_end) begin
        r_hsync_len <= r_hcnt;
      end
      // DE on the hsync start cycle belongs to the new line
      if (w_hs_start) begin
        if (r_state != ST_SEARCH) begin
          r_line_len <= w_len;
        end
        r_active_len <= r_acnt;
        r_acnt       <= w_de ? ONE : '0;
      end else if (w_de) begin
        r_acnt <= r_acnt + ONE;
      end
    end
  end

  // Active column/row tracking, frame pulse and qualified DE
  always_ff @(posedge pxclk_i) begin
    if (!resetn_i) begin
      r_col    <= '0;
      r_row    <= '0;
      r_active <= 1'b0;
      r_frame  <= 1'b0;
    end else begin
      if (w_hs_start) begin
        r_col <= '0;
      end else if (w_de) begin
        r_col <= (r_acnt == '0) ? '0 : r_col + ONE;
      end
      if (w_vs_start) begin
        r_row <= '0;
      end else if (w_hs_start && (r_acnt != '0)) begin
        r_row <= r_row + ONE;
      end
      r_frame  <= w_vs_start;
      r_active <= w_de && (r_state == ST_LOCKED);
    end
  end

  assign locked_o     = (r_state == ST_LOCKED);
  assign line_len_o   = r_line_len;
  assign hsync_len_o  = r_hsync_len;
  assign active_len_o = r_active_len;
  assign col_o        = r_col;
  assign row_o        = r_row;
  assign active_o     = r_active;
  assign frame_o      = r_frame;

endmodule
